// File: rtl/cpu_datapath_if.sv
// Controller/memory-side bundle for the accumulator CPU datapath: strobes and
// memory read data in, address/write data/enables and status back out.
interface cpu_datapath_if #(
  parameter int DWIDTH = 8,
  parameter int OPW    = 3
);
  localparam int AWIDTH = DWIDTH - OPW;

  logic              load_ir;
  logic              inc_pc;
  logic              load_pc;
  logic              load_ac;
  logic              mem_rd;
  logic              mem_wr;
  logic              halt;
  logic              sel;
  logic [DWIDTH-1:0] mem_rdata;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [OPW-1:0]    opcode;
  logic              zero;
  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] ac;
  logic              halted;

  modport master (
    output load_ir, inc_pc, load_pc, load_ac, mem_rd, mem_wr, halt, sel, mem_rdata,
    input  mem_addr, mem_wdata, mem_re, mem_we, opcode, zero, pc, ac, halted
  );

  modport slave (
    input  load_ir, inc_pc, load_pc, load_ac, mem_rd, mem_wr, halt, sel, mem_rdata,
    output mem_addr, mem_wdata, mem_re, mem_we, opcode, zero, pc, ac, halted
  );
endinterface

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: PC, IR, AC, sticky halt latch and ALU, driven by
// the sequencing controller strobes.
module cpu_datapath #(
  parameter int DWIDTH = 8,
  parameter int OPW    = 3
) (
  input  logic           clk,
  input  logic           rst,
  cpu_datapath_if.slave  bus
);
  localparam int AWIDTH = DWIDTH - OPW;

  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA = OPW'(5);

  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] ir;
  logic [DWIDTH-1:0] ac;
  logic              halted;
  logic [OPW-1:0]    op;
  logic [AWIDTH-1:0] operand;
  logic [DWIDTH-1:0] alu_out;
  logic              freeze;

  function automatic logic [DWIDTH-1:0] alu(input logic [OPW-1:0]    f,
                                            input logic [DWIDTH-1:0] a,
                                            input logic [DWIDTH-1:0] b);
    logic [DWIDTH-1:0] r;
    case (f)
      OP_ADD:  r = a + b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_LDA:  r = b;
      default: r = a;
    endcase
    return r;
  endfunction

  assign op      = ir[DWIDTH-1:AWIDTH];
  assign operand = ir[AWIDTH-1:0];
  assign alu_out = alu(op, ac, bus.mem_rdata);
  // The halt request freezes state on the very edge it is first sampled.
  assign freeze  = bus.halt | halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      ir     <= '0;
      ac     <= '0;
      halted <= 1'b0;
    end else begin
      if (bus.halt) halted <= 1'b1;
      if (!freeze) begin
        if (bus.load_pc)     pc <= operand;
        else if (bus.inc_pc) pc <= pc + AWIDTH'(1);
        if (bus.load_ir) ir <= bus.mem_rdata;
        if (bus.load_ac) ac <= alu_out;
      end
    end
  end

  assign bus.mem_addr  = bus.sel ? pc : operand;
  assign bus.mem_wdata = ac;
  assign bus.mem_re    = bus.mem_rd & ~halted;
  assign bus.mem_we    = bus.mem_wr & ~halted;
  assign bus.opcode    = op;
  assign bus.zero      = (ac == '0);
  assign bus.pc        = pc;
  assign bus.ac        = ac;
  assign bus.halted    = halted;
endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Datapath stage directly downstream of the sequencing controller in the 8-bit accumulator CPU.
- Consumes the controller strobes: load_ir, inc_pc, load_pc, load_ac, mem_rd, mem_wr and halt.
- Holds the program counter (PC), instruction register (IR), accumulator (AC) and a sticky halt latch; contains the ALU.
- Returns the opcode and zero flag to the controller, and drives the memory address, write data and read/write enables.

Parameters:
- DWIDTH, 8, data/instruction width; IR = {opcode, operand}.
- OPW, 3, opcode width; operand/address width AWIDTH = DWIDTH-OPW (5 by default), a derived localparam.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load_ir  input  1  load IR from mem_rdata.
- inc_pc  input  1  PC increment.
- load_pc  input  1  load PC from IR operand.
- load_ac  input  1  load AC from ALU result.
- mem_rd  input  1  controller read strobe.
- mem_wr  input  1  controller write strobe.
- halt  input  1  controller halt request.
- sel  input  1  address select: 1 = PC, 0 = IR operand.
- mem_rdata  input  DWIDTH  memory read data.
- mem_addr  output  AWIDTH  memory address.
- mem_wdata  output  DWIDTH  memory write data; always equals AC.
- mem_re  output  1  gated read enable.
- mem_we  output  1  gated write enable.
- opcode  output  OPW  IR[DWIDTH-1:AWIDTH], fed to the controller.
- zero  output  1  (AC == 0), combinational from AC.
- pc  output  AWIDTH  current PC.
- ac  output  DWIDTH  current AC.
- halted  output  1  sticky halt status.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=0, IR=0, ac=0, halted=0.
  - Hence opcode=000 and zero=1 after reset.
  - rst overrides every other input, including mid-instruction and while halted.
- Halt latch:
  - halted<=1 at any edge where halt=1.
  - It stays set until rst.
- Register freeze:
  - At any edge where halt=1 or halted=1, PC, IR and AC hold.
  - This includes the edge on which halt is first sampled.
- PC priority (not frozen): load_pc > inc_pc > hold.
  - load_pc: pc<=IR operand.
  - inc_pc: pc<=pc+1 modulo 2^AWIDTH (31 wraps to 0); no carry out.
  - Both asserted together: load_pc wins.
- IR: load_ir loads mem_rdata; otherwise IR holds.
- AC: load_ac loads alu_out; otherwise AC holds.
- ALU is combinational on IR opcode, AC and mem_rdata. The opcode comes from IR, never from mem_rdata.
  - 010 ADD: ac+mem_rdata, truncated to DWIDTH (0xFF+0x01 = 0x00).
  - 011 AND: ac & mem_rdata.
  - 100 XOR: ac ^ mem_rdata.
  - 101 LDA: mem_rdata.
  - 000 HLT, 001 SKZ, 110 STO, 111 JMP: ac (load_ac is a no-op).
- Memory interface:
  - mem_addr = sel ? pc : IR operand; combinational, no added latency.
  - mem_re = mem_rd & ~halted.
  - mem_we = mem_wr & ~halted.
  - mem_rd and mem_wr asserted together: both pass; the controller prevents this and the block does not arbitrate.
- Latency:
  - Register updates are visible one cycle after the strobe edge.
  - zero updates in the same cycle that AC changes.
  - opcode updates in the same cycle that IR changes.
- Simultaneous events:
  - load_ir and load_ac together: AC uses the old IR opcode; IR takes mem_rdata.
  - load_pc and load_ir together: PC takes the old IR operand.
- No internal state beyond PC, IR, AC and halted. Unknown strobe combinations follow the priority rules above.

Test Plan:
- Reset: rst=1 for one edge with arbitrary strobes -> pc=0, ac=0, opcode=000, zero=1, halted=0, mem_we=0.
- LDA: mem_rdata=8'hA3 with load_ir -> opcode=101, operand=5'h03.
  - Then sel=0 -> mem_addr=5'h03.
  - Then mem_rdata=8'h00 with load_ac -> ac=0, zero=1.
- ADD wrap: ac=8'hFF, IR=8'h41, mem_rdata=8'h01, load_ac -> ac=8'h00, zero=1.
  - Then XOR (IR=8'h81) with mem_rdata=8'h5A -> ac=8'h5A, zero=0.
- PC wrap and priority:
  - pc=31, inc_pc -> pc=0.
  - IR=8'hE9 with load_pc and inc_pc both asserted -> pc=9, not 1.
  - sel=1 -> mem_addr=9.
- STO gating:
  - ac=8'h3C, IR=8'hC7, sel=0, mem_wr=1 -> mem_addr=7, mem_wdata=8'h3C, mem_we=1.
  - Same stimulus after halt -> mem_we=0.
- Halt sticky: pulse halt one cycle alongside inc_pc and load_ac.
  - Response: pc and ac unchanged at that edge; halted=1 indefinitely; later strobes are ignored.
  - rst=1 mid-halt -> all registers return to reset values and halted=0.
